channel_receiver: RTL and testbench

CHANNEL_RECEIVER -- requirements
Module: channel_receiver

---
 rtl/rx_pkg.sv | 22 ++
 rtl/rx_sym_fifo.sv | 53 +++++
 rtl/channel_receiver.sv | 132 +++++++++++++
 tb/tb_channel_receiver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types and helpers for the channel receiver: FSM encoding, accumulator
// width and the SPS-scaled slicer threshold computation.
package rx_pkg;

   localparam int ACC_W = 20;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      INTEG  = 2'd1,
      DECIDE = 2'd2
   } state_t;

   // Threshold at (halves*LEVEL/2)*SPS, so slicing a window sum needs no divider.
   function automatic logic signed [ACC_W-1:0] slice_thresh(input int level,
                                                             input int sps,
                                                             input int halves);
      int t;
      t = ((halves * level) / 2) * sps;
      return ACC_W'(t);
   endfunction

endpackage

// File: rtl/rx_sym_fifo.sv
// Show-ahead symbol FIFO with extra-bit pointers; flags a push lost to a full
// buffer so the owner can count drops.
module rx_sym_fifo #(
   parameter int FIFO_DEPTH = 8,
   parameter int WIDTH      = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic             overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             do_read;
   logic             do_write;

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

   // A read frees a slot in the same cycle, so a push while full still lands.
   assign do_read  = pop && !empty;
   assign do_write = push && (!full || do_read);
   assign overflow = push && full && !do_read;

   assign dout = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_ptr_reg[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_read)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

endmodule

// File: rtl/channel_receiver.sv
// Integrate-and-dump receiver: sums SPS samples per symbol window, slices the
// sum into a 4-level symbol and buffers decided symbols in a FIFO.
module channel_receiver
   import rx_pkg::*;
#(
   parameter int SPS        = 60,
   parameter int LEVEL      = 600,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic signed [13:0] rx_in,
   input  logic              rd_en,
   output logic signed [1:0] rd_data,
   output logic              fifo_empty,
   output logic              fifo_full,
   output logic              sym_valid,
   output logic              frame_err,
   output logic [7:0]        drop_cnt
);

   localparam logic signed [ACC_W-1:0] THR_M2 = slice_thresh(LEVEL, SPS, -3);
   localparam logic signed [ACC_W-1:0] THR_M1 = slice_thresh(LEVEL, SPS, -1);
   localparam logic signed [ACC_W-1:0] THR_P1 = slice_thresh(LEVEL, SPS, 1);

   state_t                  state_reg, state_next;
   logic signed [ACC_W-1:0] acc_reg, acc_next;
   logic [6:0]              cnt_reg, cnt_next;
   logic                    frame_err_reg, frame_err_next;
   logic [7:0]              drop_cnt_reg;
   logic signed [ACC_W-1:0] rx_ext;
   logic                    push;
   logic [1:0]              symbol;
   logic [1:0]              fifo_dout;
   logic                    overflow;

   assign rx_ext = {{(ACC_W-14){rx_in[13]}}, rx_in};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         acc_reg       <= '0;
         cnt_reg       <= '0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         acc_reg       <= acc_next;
         cnt_reg       <= cnt_next;
         frame_err_reg <= frame_err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      acc_next       = acc_reg;
      cnt_next       = cnt_reg;
      frame_err_next = 1'b0;
      push           = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rx_valid) begin
               acc_next   = rx_ext;
               cnt_next   = 7'd1;
               state_next = INTEG;
            end
         end
         INTEG: begin
            if (rx_valid) begin
               acc_next = acc_reg + rx_ext;
               cnt_next = cnt_reg + 7'd1;
               if (cnt_reg + 7'd1 == 7'(SPS)) state_next = DECIDE;
            end else begin
               acc_next       = '0;
               cnt_next       = '0;
               frame_err_next = 1'b1;
               state_next     = IDLE;
            end
         end
         DECIDE: begin
            push = 1'b1;
            // The decision cycle's sample opens the next window, so bursts need no gap.
            if (rx_valid) begin
               acc_next   = rx_ext;
               cnt_next   = 7'd1;
               state_next = INTEG;
            end else begin
               acc_next   = '0;
               cnt_next   = '0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      if (acc_reg < THR_M2)      symbol = 2'b10;
      else if (acc_reg < THR_M1) symbol = 2'b11;
      else if (acc_reg < THR_P1) symbol = 2'b00;
      else                       symbol = 2'b01;
   end

   rx_sym_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .WIDTH     (2)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .din     (symbol),
      .pop     (rd_en),
      .dout    (fifo_dout),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .overflow(overflow)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_cnt_reg <= '0;
      end else if (overflow && drop_cnt_reg != 8'hFF) begin
         drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
   end

   assign rd_data   = fifo_dout;
   assign sym_valid = (state_reg == DECIDE);
   assign frame_err = frame_err_reg;
   assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_channel_receiver.sv
// Directed bench for channel_receiver: a window/queue model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_channel_receiver;

   localparam int SPS   = 60;
   localparam int LEVEL = 600;
   localparam int DEPTH = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              rx_valid = 1'b0;
   logic signed [13:0] rx_in = '0;
   logic              rd_en = 1'b0;
   logic signed [1:0] rd_data;
   logic              fifo_empty;
   logic              fifo_full;
   logic              sym_valid;
   logic              frame_err;
   logic [7:0]        drop_cnt;

   int checks = 0;
   int failures = 0;

   channel_receiver #(
      .SPS       (SPS),
      .LEVEL     (LEVEL),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_valid  (rx_valid),
      .rx_in     (rx_in),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .fifo_empty(fifo_empty),
      .fifo_full (fifo_full),
      .sym_valid (sym_valid),
      .frame_err (frame_err),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Symbol = nearest integer of sum/(LEVEL*SPS), ties upward, clamped to [-2,1].
   function automatic int model_sym(input int sum);
      real x;
      int  s;
      x = $floor((2.0 * sum + LEVEL * SPS) / (2.0 * LEVEL * SPS));
      s = int'(x);
      if (s < -2) s = -2;
      if (s > 1)  s = 1;
      return s;
   endfunction

   int q[$];
   int m_cnt, m_sum, m_drop, m_sym;
   bit m_dec, m_ferr;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         q.delete();
         m_cnt = 0; m_sum = 0; m_drop = 0; m_sym = 0;
         m_dec = 0; m_ferr = 0;
      end else begin
         if (rd_en && q.size() > 0) void'(q.pop_front());
         if (m_dec) begin
            if (q.size() < DEPTH) q.push_back(m_sym);
            else if (m_drop < 255) m_drop++;
         end
         m_dec  = 0;
         m_ferr = 0;
         if (rx_valid) begin
            m_sum += int'(rx_in);
            m_cnt++;
            if (m_cnt == SPS) begin
               m_sym = model_sym(m_sum);
               m_dec = 1;
               m_cnt = 0;
               m_sum = 0;
            end
         end else if (m_cnt > 0) begin
            m_ferr = 1;
            m_cnt  = 0;
            m_sum  = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("sym_valid", int'(sym_valid), int'(m_dec));
         chk("frame_err", int'(frame_err), int'(m_ferr));
         chk("fifo_empty", int'(fifo_empty), int'(q.size() == 0));
         chk("fifo_full", int'(fifo_full), int'(q.size() == DEPTH));
         chk("drop_cnt", int'(drop_cnt), m_drop);
         chk("rd_data", int'(rd_data), (q.size() > 0) ? q[0] : 0);
      end
   end

   task automatic cyc(input bit v, input int x, input bit r);
      rx_valid = v;
      rx_in    = 14'(x);
      rd_en    = r;
      @(posedge clk);
      #2;
   endtask

   task automatic burst(input int n, input int x);
      for (int i = 0; i < n; i++) cyc(1'b1, x, 1'b0);
   endtask

   initial begin
      int lv[4];
      lv[0] = -1200; lv[1] = -600; lv[2] = 0; lv[3] = 600;

      // reset state
      #12;
      chk("rst_empty", int'(fifo_empty), 1);
      chk("rst_full", int'(fifo_full), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      chk("rst_sym_valid", int'(sym_valid), 0);
      chk("rst_frame_err", int'(frame_err), 0);
      chk("rst_drop", int'(drop_cnt), 0);
      #1 reset = 1'b0;
      @(posedge clk);
      #2;
      $display("txn: reset released");

      // 600 x 60 -> +1, decision visible in cycle 61
      burst(SPS, 600);
      chk("t1_sym_valid", int'(sym_valid), 1);
      cyc(1'b0, 0, 1'b0);
      chk("t1_rd_data", int'(rd_data), 1);
      chk("t1_drop", int'(drop_cnt), 0);
      cyc(1'b0, 0, 1'b1);
      chk("t1_empty", int'(fifo_empty), 1);
      $display("txn: 600x60 -> +1");

      // back-to-back windows -> -2 then -1
      burst(SPS, -1200);
      burst(SPS, -600);
      cyc(1'b0, 0, 1'b0);
      chk("t2_first", int'(rd_data), -2);
      cyc(1'b0, 0, 1'b1);
      chk("t2_second", int'(rd_data), -1);
      cyc(1'b0, 0, 1'b1);
      $display("txn: contiguous -1200/-600 -> -2,-1");

      // threshold boundary
      burst(SPS, 300);
      cyc(1'b0, 0, 1'b0);
      chk("t3_acc18000", int'(rd_data), 1);
      cyc(1'b0, 0, 1'b1);
      burst(SPS - 1, 300);
      cyc(1'b1, 299, 1'b0);
      cyc(1'b0, 0, 1'b0);
      chk("t3_acc17999", int'(rd_data), 0);
      cyc(1'b0, 0, 1'b1);
      $display("txn: boundary 18000/17999");

      // partial window
      burst(30, 500);
      cyc(1'b0, 0, 1'b0);
      chk("t4_frame_err", int'(frame_err), 1);
      chk("t4_sym_valid", int'(sym_valid), 0);
      cyc(1'b0, 0, 1'b0);
      chk("t4_frame_err_off", int'(frame_err), 0);
      chk("t4_empty", int'(fifo_empty), 1);
      $display("txn: partial window -> frame_err");

      // overflow: nine windows, no reads
      for (int w = 0; w < 9; w++) begin
         for (int s = 0; s < SPS; s++) begin
            cyc(1'b1, lv[w % 4], 1'b0);
            if (w == 8 && s == 0) chk("t5_full_after8", int'(fifo_full), 1);
         end
      end
      cyc(1'b0, 0, 1'b0);
      chk("t5_drop1", int'(drop_cnt), 1);
      chk("t5_head", int'(rd_data), -2);
      burst(SPS, lv[1]);
      cyc(1'b0, 0, 1'b1);
      chk("t5_drop_stays", int'(drop_cnt), 1);
      chk("t5_full_kept", int'(fifo_full), 1);
      chk("t5_new_head", int'(rd_data), -1);
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 0, 1'b1);
      chk("t5_drained", int'(fifo_empty), 1);
      $display("txn: overflow drop_cnt=%0d", drop_cnt);

      // asynchronous reset mid-window
      burst(SPS, 600);
      cyc(1'b0, 0, 1'b0);
      burst(40, 600);
      #1 reset = 1'b1;
      #1;
      chk("t6_empty", int'(fifo_empty), 1);
      chk("t6_rd_data", int'(rd_data), 0);
      chk("t6_drop", int'(drop_cnt), 0);
      chk("t6_frame_err", int'(frame_err), 0);
      chk("t6_sym_valid", int'(sym_valid), 0);
      #3 reset = 1'b0;
      @(posedge clk);
      #2;
      burst(SPS, -600);
      cyc(1'b0, 0, 1'b0);
      chk("t6_after_rst", int'(rd_data), -1);
      cyc(1'b0, 0, 1'b1);
      cyc(1'b0, 0, 1'b0);
      $display("txn: async reset mid-window, next burst -> -1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
